// File: rtl/seq_divider_pkg.sv
// Shared CPU package: divider FSM encodings, default iteration count and
// a small absolute-value helper used when loading signed operands.
package seq_divider_pkg;

  localparam int DIV_CYCLES_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/seq_divider_div_iter.sv
// One restoring-division step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only when no borrow occurs.
module div_iter (
  input  logic [32:0] i_rem,
  input  logic [31:0] i_divisor,
  input  logic        i_bit,
  output logic [32:0] o_rem,
  output logic        o_qbit
);

  logic [33:0] w_shifted;
  logic [32:0] w_diff;
  logic        w_borrow;

  assign w_shifted = {i_rem, i_bit};
  assign w_borrow  = (w_shifted < {2'b00, i_divisor});
  assign w_diff    = w_shifted[32:0] - {1'b0, i_divisor};
  assign o_qbit    = ~w_borrow;
  assign o_rem     = w_borrow ? w_shifted[32:0] : w_diff;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle 32-bit DIV/DIVU unit for the E stage: holds the pipeline via
// stall while iterating, then presents quotient/remainder in the DONE cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        stall,
  output logic        done,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  div_state_t r_state;
  div_state_t w_next_state;

  logic [CNT_W-1:0] r_count;
  logic [32:0]      r_rem;
  logic [31:0]      r_dividend;
  logic [31:0]      r_divisor;
  logic             r_qneg;
  logic             r_rneg;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi;

  logic [32:0] w_rem_next;
  logic        w_qbit;
  logic        w_last;
  logic        w_launch;
  logic [31:0] w_quot;
  logic [31:0] w_rem_mag;

  div_iter u_iter (
    .i_rem     (r_rem),
    .i_divisor (r_divisor),
    .i_bit     (r_dividend[31]),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  assign w_launch  = (r_state == ST_IDLE) && start && !cancel;
  assign w_last    = (r_count == CNT_W'(DIV_CYCLES - 1));
  assign w_quot    = {r_dividend[30:0], w_qbit};
  assign w_rem_mag = w_rem_next[31:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          stall        = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          w_next_state = ST_IDLE;
        end else begin
          stall = 1'b1;
          if (w_last) w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done         = !cancel;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Divide-by-zero loads raw operands with no sign flags, so the all-ones
  // quotient and untouched dividend come out exactly as the MIPS view expects.
  // Results are registered on the final RUN step so they are already on
  // lo/hi during the DONE cycle when the pipeline advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_rem      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
    end else if (w_launch) begin
      r_count <= '0;
      r_rem   <= '0;
      if (is_signed && (b != 32'd0)) begin
        r_dividend <= abs32(a);
        r_divisor  <= abs32(b);
        r_qneg     <= a[31] ^ b[31];
        r_rneg     <= a[31];
      end else begin
        r_dividend <= a;
        r_divisor  <= b;
        r_qneg     <= 1'b0;
        r_rneg     <= 1'b0;
      end
    end else if ((r_state == ST_RUN) && !cancel) begin
      r_count    <= r_count + 1'b1;
      r_rem      <= w_rem_next;
      r_dividend <= w_quot;
      if (w_last) begin
        r_lo <= r_qneg ? -w_quot : w_quot;
        r_hi <= r_rneg ? -w_rem_mag : w_rem_mag;
      end
    end
  end

  assign lo = r_lo;
  assign hi = r_hi;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, number of iteration cycles (one quotient bit per cycle).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port start, input, 1, divide instruction present in E stage (div_signalE); level, held while stalled.
REQ-005 SHALL have port is_signed, input, 1, 1 = DIV, 0 = DIVU; sampled with start.
REQ-006 SHALL have port a, input, 32, dividend (rs value); sampled with start.
REQ-007 SHALL have port b, input, 32, divisor (rt value); sampled with start.
REQ-008 SHALL have port cancel, input, 1, exception flush (flush_except); aborts any operation.
REQ-009 SHALL have port stall, output, 1, stall request to the hazard unit (stall_divE).
REQ-010 SHALL have port done, output, 1, one-cycle pulse when results become valid.
REQ-011 SHALL have port lo, output, 32, quotient.
REQ-012 SHALL have port hi, output, 32, remainder.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE & start & ~cancel SHALL latch operands, record the quotient sign (a[31]^b[31]) and remainder sign (a[31]) when signed, load absolute values, clear the iteration counter, and go to RUN.
REQ-015 RUN SHALL perform one restoring step per cycle: 33-bit partial remainder shifted left with next dividend bit, subtract |b|, quotient bit = no borrow, restore on borrow.
REQ-016 RUN SHALL go to DONE after exactly DIV_CYCLES steps (counter reaches DIV_CYCLES-1).
REQ-017 DONE SHALL apply sign fix-up (negate quotient if the quotient sign is set; negate remainder if the remainder sign is set), register lo/hi, pulse done, and return to IDLE next cycle unconditionally.
REQ-018 stall SHALL be combinational: (IDLE & start & ~cancel) | (RUN & ~cancel); low in DONE.
REQ-019 The stall SHALL span the start cycle plus DIV_CYCLES RUN cycles (33 cycles at default); results SHALL be valid on lo/hi in the DONE cycle, when the pipeline advances.
REQ-020 start still high in DONE SHALL NOT restart; start high in the IDLE cycle after DONE (a back-to-back divide) SHALL start a new operation.
REQ-021 Divide by zero SHALL take the full latency and yield lo=32'hFFFFFFFF, hi=a (unsigned view, no sign fix-up).
REQ-022 Signed 32'h80000000 / 32'hFFFFFFFF SHALL yield lo=32'h80000000, hi=0.
REQ-023 cancel in any state SHALL return the FSM to IDLE next cycle with no done pulse, and leave lo/hi at their previous values.
REQ-024 cancel and start asserted together in IDLE SHALL NOT start an operation.
REQ-025 lo/hi SHALL hold their values until the next DONE.

Reset
REQ-026 rst SHALL force state=IDLE, counter=0, lo=0, hi=0, done=0, and internal datapath registers=0; stall SHALL then be 0 unless start is high.
REQ-027 rst during RUN SHALL abort the operation with no done pulse.

Structure
REQ-028 State encodings and DIV_CYCLES default SHALL live in the shared CPU package (e.g. alongside the ALU op constants).
REQ-029 The single restoring step SHALL be a sub-module div_iter (33-bit remainder in, divisor, next bit in; remainder out, quotient bit out); the FSM and sign fix-up stay in seq_divider.

Verification
REQ-030 Unsigned 100/7 -> stall high 33 cycles, done in cycle 33, lo=14, hi=2.
REQ-031 Signed -7/2 (32'hFFFFFFF9/2) -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; signed 7/-2 -> lo=32'hFFFFFFFD, hi=1.
REQ-032 Unsigned 5/0 -> same latency, lo=32'hFFFFFFFF, hi=5.
REQ-033 Complete 100/7, then start 50/3; cancel in RUN cycle 10 -> stall 0 that cycle, no done pulse, lo=14 and hi=2 retained, FSM in IDLE.
REQ-034 Two back-to-back divides (start held through the first DONE, new operands the next cycle) -> exactly two done pulses, second stall begins in the cycle after DONE, both results correct.
REQ-035 rst in RUN cycle 5 -> state IDLE, lo=hi=0, no done pulse; a subsequent 9/4 -> lo=2, hi=1.
